// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI arbiters: FSM state encoding and select-width helper.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_e;

  // Width of an index that selects one of n masters (at least 1 bit).
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_rr_fifo.sv
// In-order FIFO of master indices; records who owns each outstanding response.
module arb_rr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; empty/count guard every read, so
  // stale entries are never observed and the array maps onto plain registers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one AXI write channel set (AW/W/B) among masters;
// emits select indices for an external payload mux.
module axi_write_arbiter
  import axi_arb_pkg::*;
#(
  parameter int INPUT_NUM       = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int SEL_W           = sel_width(INPUT_NUM)
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [INPUT_NUM-1:0] s_awvalid_i,
  output logic [INPUT_NUM-1:0] s_awready_o,
  input  logic [INPUT_NUM-1:0] s_wvalid_i,
  input  logic [INPUT_NUM-1:0] s_wlast_i,
  output logic [INPUT_NUM-1:0] s_wready_o,
  output logic [INPUT_NUM-1:0] s_bvalid_o,
  input  logic [INPUT_NUM-1:0] s_bready_i,
  output logic                 m_awvalid_o,
  input  logic                 m_awready_i,
  output logic                 m_wvalid_o,
  output logic                 m_wlast_o,
  input  logic                 m_wready_i,
  input  logic                 m_bvalid_i,
  output logic                 m_bready_o,
  output logic [SEL_W-1:0]     aw_sel_o,
  output logic [SEL_W-1:0]     b_sel_o,
  output logic                 busy_o
);

  arb_state_e                     state;
  logic [SEL_W-1:0]               grant;
  logic [SEL_W-1:0]               prio;
  logic [SEL_W-1:0]               head;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic [$clog2(MAX_OUTSTANDING):0] fifo_count;
  logic                           aw_hs;
  logic                           w_last_hs;
  logic                           b_hs;

  // First requester at or after ptr, wrapping around.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [INPUT_NUM-1:0] req,
                                               input logic [SEL_W-1:0]     ptr);
    logic [SEL_W-1:0] pick;
    int               idx;
    pick = ptr;
    for (int k = INPUT_NUM - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % INPUT_NUM;
      if (req[idx]) pick = SEL_W'(idx);
    end
    return pick;
  endfunction

  assign aw_hs     = (state == ADDR) && s_awvalid_i[grant] && m_awready_i;
  assign w_last_hs = (state == DATA) && s_wvalid_i[grant] && m_wready_i && s_wlast_i[grant];
  assign b_hs      = !fifo_empty && m_bvalid_i && s_bready_i[head];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= IDLE;
      grant <= '0;
      prio  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((|s_awvalid_i) && !fifo_full) begin
            grant <= rr_pick(s_awvalid_i, prio);
            state <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) state <= DATA;
        end
        DATA: begin
          if (w_last_hs) begin
            prio  <= (grant == SEL_W'(INPUT_NUM - 1)) ? '0 : grant + SEL_W'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  arb_rr_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (SEL_W)
  ) u_b_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (aw_hs),
    .pop   (b_hs),
    .din   (grant),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every output gets a default before the case so no path leaves a
  // value held, which would otherwise infer a latch.
  always_comb begin
    s_awready_o = '0;
    s_wready_o  = '0;
    s_bvalid_o  = '0;
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    m_wlast_o   = 1'b0;
    m_bready_o  = 1'b0;
    case (state)
      ADDR: begin
        m_awvalid_o        = s_awvalid_i[grant];
        s_awready_o[grant] = m_awready_i;
      end
      DATA: begin
        m_wvalid_o        = s_wvalid_i[grant];
        m_wlast_o         = s_wlast_i[grant];
        s_wready_o[grant] = m_wready_i;
      end
      default: ;
    endcase
    if (!fifo_empty) begin
      s_bvalid_o[head] = m_bvalid_i;
      m_bready_o       = s_bready_i[head];
    end
  end

  assign aw_sel_o = grant;
  assign b_sel_o  = fifo_empty ? '0 : head;
  assign busy_o   = (state != IDLE) || (fifo_count != '0);

endmodule
